// File: rtl/cacheline_burst_adaptor.sv
// cacheline_burst_adaptor
// Memory-side responder that turns one 256-bit cache line request into a
// 4-beat, 64-bit burst on the physical memory port and pulses resp_o once
// the whole line has moved.

module cacheline_burst_adaptor #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         address_i,
   input  logic                read_i,
   input  logic                write_i,
   input  logic [LINE_W-1:0]   line_i,
   output logic [LINE_W-1:0]   line_o,
   output logic                resp_o,
   output logic [31:0]         address_o,
   output logic                read_o,
   output logic                write_o,
   output logic [BURST_W-1:0]  burst_o,
   input  logic [BURST_W-1:0]  burst_i,
   input  logic                resp_i
);

   localparam int BEATS = LINE_W / BURST_W;
   localparam int CNT_W = $clog2(BEATS);
   localparam int OFF_W = $clog2(LINE_W / 8);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [LINE_W-1:0]   buf_q, buf_d;
   logic [31:0]         addr_q, addr_d;

   // The byte offset inside a line never reaches memory; the line is
   // always fetched or stored as a whole.
   logic unused_addr_bits;
   assign unused_addr_bits = ^address_i[OFF_W-1:0];

   // State register plus datapath flops; reset clears everything so an
   // aborted transfer leaves no stale beats behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         buf_q   <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         addr_q  <= addr_d;
      end
   end

   // Next-state and datapath update: accept a request in IDLE (read wins
   // over write), then count only acknowledged beats until the line is done.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      addr_d  = addr_q;
      case (state_q)
         IDLE: begin
            if (read_i) begin
               addr_d  = {address_i[31:OFF_W], {OFF_W{1'b0}}};
               cnt_d   = '0;
               state_d = READ;
            end else if (write_i) begin
               addr_d  = {address_i[31:OFF_W], {OFF_W{1'b0}}};
               buf_d   = line_i;
               cnt_d   = '0;
               state_d = WRITE;
            end
         end
         READ: begin
            if (resp_i) begin
               buf_d[cnt_q*BURST_W +: BURST_W] = burst_i;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(BEATS - 1)) begin
                  state_d = DONE;
               end
            end
         end
         WRITE: begin
            if (resp_i) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(BEATS - 1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decode from registered state only, so nothing on the request
   // or acknowledge inputs can reach an output in the same cycle.
   always_comb begin
      read_o    = (state_q == READ);
      write_o   = (state_q == WRITE);
      resp_o    = (state_q == DONE);
      line_o    = buf_q;
      address_o = addr_q;
      burst_o   = '0;
      if (state_q == WRITE) begin
         burst_o = buf_q[cnt_q*BURST_W +: BURST_W];
      end
   end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// tb_cacheline_burst_adaptor
// Drives random line reads/writes against a behavioural memory model that
// tracks beats by count, and compares every visible output per cycle.

module tb_cacheline_burst_adaptor;

   logic         clk;
   logic         rst;
   logic [31:0]  address_i;
   logic         read_i;
   logic         write_i;
   logic [255:0] line_i;
   logic [255:0] line_o;
   logic         resp_o;
   logic [31:0]  address_o;
   logic         read_o;
   logic         write_o;
   logic [63:0]  burst_o;
   logic [63:0]  burst_i;
   logic         resp_i;

   int checkCount = 0;
   int failCount  = 0;

   // Reference memory-side view: what the line buffer and latched address
   // should hold whenever the adaptor is idle.
   logic [255:0] modelBuf  = '0;
   logic [31:0]  modelAddr = '0;

   cacheline_burst_adaptor #(.LINE_W(256), .BURST_W(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .address_i (address_i),
      .read_i    (read_i),
      .write_i   (write_i),
      .line_i    (line_i),
      .line_o    (line_o),
      .resp_o    (resp_o),
      .address_o (address_o),
      .read_o    (read_o),
      .write_o   (write_o),
      .burst_o   (burst_o),
      .burst_i   (burst_i),
      .resp_i    (resp_i)
   );

   // 100 MHz-style free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a handshake never completes.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [255:0] observed,
                              input logic [255:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i*32 +: 32] = $urandom;
      end
      return r;
   endfunction

   // Idle cycles with junk on the memory side; nothing may move.
   task automatic idleSpurious(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         checkOutput("idle_resp",  resp_o,    0);
         checkOutput("idle_read",  read_o,    0);
         checkOutput("idle_write", write_o,   0);
         checkOutput("idle_addr",  address_o, modelAddr);
         checkOutput("idle_line",  line_o,    modelBuf);
         read_i    = 1'b0;
         write_i   = 1'b0;
         resp_i    = 1'($urandom_range(1));
         burst_i   = {$urandom, $urandom};
         address_i = $urandom;
      end
   endtask

   // One line transaction: request in the first idle cycle, memory acks
   // after 'lat' cycles with random gaps, optional reset after abortBeats.
   task automatic applyStimulus(input bit isRead, input bit bothReq,
                                input logic [31:0] addr, input logic [255:0] line,
                                input int lat, input int gapPct,
                                input bit holdReq, input int abortBeats);
      logic [255:0] expLine;
      logic [31:0]  expAddr;
      logic [63:0]  beat;
      bit           isReadEff;
      bit           done;
      int           beatsDone;

      isReadEff = isRead | bothReq;
      expAddr   = {addr[31:5], 5'b0};
      expLine   = isReadEff ? modelBuf : line;
      beatsDone = 0;
      done      = 1'b0;

      @(negedge clk);
      checkOutput("req_idle_resp",  resp_o,    0);
      checkOutput("req_idle_read",  read_o,    0);
      checkOutput("req_idle_write", write_o,   0);
      checkOutput("req_idle_burst", burst_o,   0);
      checkOutput("req_idle_addr",  address_o, modelAddr);
      checkOutput("req_idle_line",  line_o,    modelBuf);
      read_i    = isReadEff;
      write_i   = !isRead | bothReq;
      address_i = addr;
      line_i    = line;
      resp_i    = 1'($urandom_range(1));
      burst_i   = {$urandom, $urandom};

      for (int n = 1; n < 200; n++) begin
         @(negedge clk);
         if (!holdReq) begin
            read_i  = 1'b0;
            write_i = 1'b0;
         end
         address_i = $urandom;
         line_i    = rand256();
         resp_i    = 1'b0;

         if (abortBeats != 0 && beatsDone == abortBeats) begin
            rst = 1'b1;
            #1;
            checkOutput("abort_read",  read_o,    0);
            checkOutput("abort_write", write_o,   0);
            checkOutput("abort_resp",  resp_o,    0);
            checkOutput("abort_burst", burst_o,   0);
            checkOutput("abort_line",  line_o,    0);
            checkOutput("abort_addr",  address_o, 0);
            read_i  = 1'b0;
            write_i = 1'b0;
            @(negedge clk);
            rst       = 1'b0;
            modelBuf  = '0;
            modelAddr = '0;
            return;
         end

         if (beatsDone < 4) begin
            checkOutput("busy_read",  read_o,    isReadEff);
            checkOutput("busy_write", write_o,   !isReadEff);
            checkOutput("busy_resp",  resp_o,    0);
            checkOutput("busy_addr",  address_o, expAddr);
            if (!isReadEff) begin
               checkOutput("write_beat", burst_o, expLine[beatsDone*64 +: 64]);
            end
            if (n >= lat && (n >= lat + 20 || $urandom_range(99) >= gapPct)) begin
               beat    = {$urandom, $urandom};
               burst_i = beat;
               resp_i  = 1'b1;
               if (isReadEff) begin
                  expLine[beatsDone*64 +: 64] = beat;
               end
               beatsDone++;
            end else begin
               burst_i = {$urandom, $urandom};
            end
         end else begin
            checkOutput("done_resp",  resp_o,    1);
            checkOutput("done_read",  read_o,    0);
            checkOutput("done_write", write_o,   0);
            checkOutput("done_burst", burst_o,   0);
            checkOutput("done_line",  line_o,    expLine);
            checkOutput("done_addr",  address_o, expAddr);
            modelBuf  = expLine;
            modelAddr = expAddr;
            resp_i    = 1'($urandom_range(1));
            done      = 1'b1;
            break;
         end
      end
      if (!done) begin
         checkOutput("resp_timeout", 0, 1);
      end
   endtask

   initial begin
      rst       = 1'b1;
      read_i    = 1'b0;
      write_i   = 1'b0;
      resp_i    = 1'b0;
      address_i = '0;
      line_i    = '0;
      burst_i   = '0;
      #1;
      checkOutput("rst_read",  read_o,    0);
      checkOutput("rst_write", write_o,   0);
      checkOutput("rst_resp",  resp_o,    0);
      checkOutput("rst_burst", burst_o,   0);
      checkOutput("rst_line",  line_o,    0);
      checkOutput("rst_addr",  address_o, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] directed read, first beat after latency");
      applyStimulus(1'b1, 1'b0, 32'h0000_1234, rand256(), 4, 0, 1'b1, 0);

      $display("[TB] directed write with gaps");
      applyStimulus(1'b0, 1'b0, 32'hABCD_EF1F, rand256(), 2, 40, 1'b1, 0);

      $display("[TB] simultaneous read and write request");
      applyStimulus(1'b1, 1'b1, 32'h8000_0040, rand256(), 1, 20, 1'b0, 0);

      $display("[TB] spurious acks while idle");
      idleSpurious(6);

      $display("[TB] reset mid-read after two beats");
      applyStimulus(1'b1, 1'b0, 32'h0000_5A5F, rand256(), 3, 20, 1'b1, 2);
      applyStimulus(1'b1, 1'b0, 32'h0000_7760, rand256(), 2, 20, 1'b0, 0);

      $display("[TB] back-to-back read then write");
      applyStimulus(1'b1, 1'b0, $urandom, rand256(), 1, 0, 1'b1, 0);
      applyStimulus(1'b0, 1'b0, $urandom, rand256(), 1, 0, 1'b1, 0);

      $display("[TB] random transactions");
      for (int t = 0; t < 30; t++) begin
         applyStimulus(1'($urandom_range(1)), 1'($urandom_range(3) == 0),
                       $urandom, rand256(), int'($urandom_range(6, 1)),
                       int'($urandom_range(50)), 1'($urandom_range(1)), 0);
         if ($urandom_range(3) == 0) begin
            idleSpurious(int'($urandom_range(3, 1)));
         end
      end
      idleSpurious(2);

      $display("test done: total=%0d bad=%0d", checkCount, failCount);
      $finish;
   end

endmodule
